// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM state encodings and bit-order constant for seq_pattern_tx
package seq_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SHIFT    = 2'b01,
        GAP_WAIT = 2'b10,
        DONE     = 2'b11
    } state_t;
    localparam bit MSB_FIRST = 1'b1;
endpackage

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serialises pattern[len:0] MSB-first, rpt+1 times, GAP idle cycles between repeats
//   clk, rst_n (async active-low) | start, abort, pattern, len, rpt in | d_out, valid, busy, done out (all registered)
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GAP   = 0,
    localparam int LW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    input  logic [3:0]       rpt,
    output logic             d_out,
    output logic             valid,
    output logic             busy,
    output logic             done
);
    state_t           state;
    logic [WIDTH-1:0] pat_r;
    logic [LW-1:0]    len_r;
    logic [LW-1:0]    idx;
    logic [LW-1:0]    idx_dn;
    logic [3:0]       rep;
    logic [3:0]       gcnt;

    assign idx_dn = MSB_FIRST ? idx - 1'b1 : idx + 1'b1;

    // idx is the index of the bit currently on d_out; the next bit is loaded on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pat_r <= '0;
            len_r <= '0;
            idx   <= '0;
            rep   <= '0;
            gcnt  <= '0;
            d_out <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    d_out <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start && !abort) begin
                        state <= SHIFT;
                        pat_r <= pattern;
                        len_r <= len;
                        rep   <= rpt;
                        idx   <= len;
                        d_out <= pattern[len];
                        valid <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                        d_out <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (idx == '0) begin
                        if (rep == 4'd0) begin
                            state <= DONE;
                            d_out <= 1'b0;
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            rep <= rep - 4'd1;
                            if (GAP > 0) begin
                                state <= GAP_WAIT;
                                gcnt  <= 4'(GAP - 1);
                                d_out <= 1'b0;
                                valid <= 1'b0;
                            end else begin
                                idx   <= len_r;
                                d_out <= pat_r[len_r];
                            end
                        end
                    end else begin
                        idx   <= idx_dn;
                        d_out <= pat_r[idx_dn];
                    end
                end
                GAP_WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                        d_out <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (gcnt == 4'd0) begin
                        state <= SHIFT;
                        idx   <= len_r;
                        d_out <= pat_r[len_r];
                        valid <= 1'b1;
                    end else begin
                        gcnt <= gcnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    d_out <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed + randomized checks of seq_pattern_tx against a per-cycle expected stream
module tb_seq_pattern_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0, abort = 1'b0;
    logic [15:0] pattern = '0;
    logic [3:0]  len = '0, rpt = '0;
    logic        d0, v0, b0, n0, d1, v1, b1, n1;
    int          checks = 0, errors = 0;
    bit          q_v[$];
    bit          q_d[$];
    int          nv, det;

    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(16), .GAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .pattern(pattern),
        .len(len), .rpt(rpt), .d_out(d0), .valid(v0), .busy(b0), .done(n0));

    seq_pattern_tx #(.WIDTH(16), .GAP(2)) dut_g (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .pattern(pattern),
        .len(len), .rpt(rpt), .d_out(d1), .valid(v1), .busy(b1), .done(n1));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input bit sel, input string tag, input int v, input int d, input int b, input int n);
        chk({tag, ".valid"}, int'(sel ? v1 : v0), v);
        chk({tag, ".d_out"}, int'(sel ? d1 : d0), d);
        chk({tag, ".busy"},  int'(sel ? b1 : b0), b);
        chk({tag, ".done"},  int'(sel ? n1 : n0), n);
    endtask

    // Called at a negedge; builds the expected stream from the rules and follows the transfer to idle.
    task automatic send(input bit sel, input logic [15:0] p, input logic [3:0] l, input logic [3:0] r, input bit poke);
        logic [3:0] hist;
        int gap;
        gap = sel ? 2 : 0;
        q_v.delete();
        q_d.delete();
        for (int k = 0; k <= int'(r); k++) begin
            for (int b = int'(l); b >= 0; b--) begin
                q_v.push_back(1'b1);
                q_d.push_back(p[b]);
            end
            if (k < int'(r))
                for (int g = 0; g < gap; g++) begin
                    q_v.push_back(1'b0);
                    q_d.push_back(1'b0);
                end
        end
        pattern = p; len = l; rpt = r;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        nv = 0; det = 0; hist = '0;
        for (int i = 0; i < q_v.size(); i++) begin
            chk_out(sel, $sformatf("bit%0d", i), int'(q_v[i]), int'(q_d[i]), 1, 0);
            if (sel ? v1 : v0) begin
                nv++;
                hist = {hist[2:0], sel ? d1 : d0};
                if (hist == 4'b1011) det++;
            end
            pattern = 16'($urandom); len = 4'($urandom); rpt = 4'($urandom);
            if (sel) start1 = poke && i == 1; else start0 = poke && i == 1;
            @(negedge clk);
        end
        start0 = 1'b0; start1 = 1'b0;
        chk("valid_count", nv, (int'(l) + 1) * (int'(r) + 1));
        chk_out(sel, "done_cycle", 0, 0, 1, 1);
        @(negedge clk);
        chk_out(sel, "back_idle", 0, 0, 0, 0);
    endtask

    initial begin
        #1 chk_out(0, "reset", 0, 0, 0, 0);
        chk_out(1, "reset_g", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // first start on the first edge after release
        send(0, 16'h000B, 4'd3, 4'd0, 0);
        send(0, 16'h000B, 4'd3, 4'd2, 0);
        chk("detector_1011", det, 3);
        send(1, 16'h0005, 4'd2, 4'd1, 0);
        send(0, 16'hFFF5, 4'd2, 4'd0, 1);
        send(0, 16'h0001, 4'd0, 4'd15, 0);
        send(0, 16'h8001, 4'd15, 4'd0, 0);
        send(1, 16'h0001, 4'd0, 4'd3, 1);
        // abort on the third bit of a 16-bit send
        pattern = 16'hA5C3; len = 4'd15; rpt = 4'd0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        chk_out(0, "pre_abort", 1, int'(pattern[14]), 1, 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_out(0, "post_abort", 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", int'(n0), 0);
        end
        // abort during a gap
        send(1, 16'h0003, 4'd1, 4'd0, 0);
        pattern = 16'h0003; len = 4'd1; rpt = 4'd2; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        chk_out(1, "in_gap", 0, 0, 1, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_out(1, "gap_abort", 0, 0, 0, 0);
        // start and abort together in idle: abort wins
        start0 = 1'b1; abort = 1'b1;
        @(negedge clk);
        start0 = 1'b0; abort = 1'b0;
        chk_out(0, "start_abort", 0, 0, 0, 0);
        // abort alone in idle does nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        send(0, 16'h0006, 4'd2, 4'd1, 0);
        // mid-send reset clears outputs immediately
        pattern = 16'hFFFF; len = 4'd15; rpt = 4'd3; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        chk_out(0, "pre_reset", 1, 1, 1, 0);
        rst_n = 1'b0;
        #1 chk_out(0, "async_reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 16'h0009, 4'd3, 4'd0, 0);
        // randomized sends on both instances
        for (int t = 0; t < 24; t++)
            send(t % 2 == 1, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 4)), t % 3 == 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter WIDTH, default 16, maximum pattern length in bits.
REQ-002 Parameter GAP, default 0, number of idle cycles inserted between repetitions (range 0..15).
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a transmission; honoured only in IDLE.
REQ-006 abort  input  1  synchronous cancel of an active transmission.
REQ-007 pattern  input  WIDTH  bit pattern, sent MSB-first from bit len down to bit 0.
REQ-008 len  input  $clog2(WIDTH)  index of the first bit sent; pattern length is len+1.
REQ-009 rpt  input  4  repeat count; the pattern is sent rpt+1 times.
REQ-010 d_out  output  1  serial data bit, registered.
REQ-011 valid  output  1  high in every cycle that d_out carries a pattern bit.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 done  output  1  one-cycle pulse after normal completion.

Function
REQ-014 The FSM SHALL have the states IDLE, SHIFT, GAP_WAIT and DONE, held in a 2-bit state register.
REQ-015 IDLE: start=1 SHALL capture pattern, len and rpt into internal registers and go to SHIFT; d_out, valid and done SHALL be 0.
REQ-016 The first bit (pattern[len]) SHALL appear on d_out with valid=1 in the cycle after start was sampled, a latency of 1.
REQ-017 SHIFT SHALL send one bit per cycle, decrementing the bit index from len to 0.
REQ-018 At bit index 0 with repetitions remaining, the FSM SHALL go to GAP_WAIT if GAP>0, otherwise back to SHIFT at index len with no bubble.
REQ-019 At bit index 0 on the final repetition, the FSM SHALL go to DONE.
REQ-020 GAP_WAIT SHALL hold d_out=0 and valid=0 for exactly GAP cycles, then return to SHIFT at index len.
REQ-021 DONE SHALL last one cycle with done=1 and busy=1, then go to IDLE.
REQ-022 The total number of valid cycles SHALL be (len+1)*(rpt+1).
REQ-023 The cycles from start to done SHALL number (len+1)*(rpt+1) + GAP*rpt + 1.
REQ-024 start SHALL be ignored in SHIFT, GAP_WAIT and DONE, and input changes while busy SHALL not affect the transmission in progress.
REQ-025 abort=1 in SHIFT or GAP_WAIT SHALL force IDLE on the next edge, with valid=0 and d_out=0 from that cycle and no done pulse.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 If start and abort are both high in IDLE, abort SHALL win and no transmission SHALL begin.
REQ-028 len=0 SHALL send one bit per repetition.
REQ-029 rpt=0 SHALL send the pattern once.
REQ-030 Bits of pattern above index len SHALL be ignored.
REQ-031 An unreachable state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE and d_out=0, valid=0, busy=0, done=0, and clear the counters and captured registers.
REQ-033 Asserting reset mid-transmission SHALL abandon the transmission with no done pulse.
REQ-034 Release of reset SHALL be synchronised by the integrating level, and the first start SHALL be accepted on the first edge after release.

Structure
REQ-035 The state encodings (IDLE=2'b00, SHIFT=2'b01, GAP_WAIT=2'b10, DONE=2'b11) SHALL live in shared package seq_pkg, together with the MSB-first constant.
REQ-036 The block SHALL be a single module with no sub-modules; the bit-index, repetition and gap counters SHALL be inline registers.
REQ-037 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Verification
REQ-038 Basic send: pattern=16'h000B, len=3, rpt=0, GAP=0, start pulse -> d_out=1,0,1,1 with valid=1 on cycles 1-4 and done on cycle 5.
REQ-039 Repeat into detector: as REQ-038 with rpt=2, d_out feeding mealy 1011 detector d_in -> detector output pulses exactly 3 times and done occurs on cycle 13.
REQ-040 Gap: GAP=2, pattern=16'h0005, len=2, rpt=1 -> 1,0,1, two cycles of valid=0, then 1,0,1, with done on cycle 9.
REQ-041 Abort: abort asserted on the 3rd bit of a 16-bit send -> valid=0 on the next cycle, busy=0, done never asserts, and a new start is accepted afterwards.
REQ-042 Ignored start and mid-run reset: start re-pulsed while busy -> no restart and the bit count is unchanged; rst_n pulsed low mid-send -> all outputs 0 immediately.
REQ-043 Edge lengths: len=0, rpt=15 -> exactly 16 valid cycles; len=WIDTH-1, pattern=16'h8001 -> first and last bits are 1 and the rest are 0.
